// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared opcodes, instruction field positions and fetch state encoding
package proc_pkg;

    localparam logic [7:0] OP_ADD  = 8'h88;
    localparam logic [7:0] OP_SUB  = 8'h89;
    localparam logic [7:0] OP_INC  = 8'h8A;
    localparam logic [7:0] OP_HALT = 8'hFF;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 24;
    localparam int OP2_MSB    = 15;
    localparam int OP2_LSB    = 8;
    localparam int OP1_MSB    = 7;
    localparam int OP1_LSB    = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READ    = 2'd1,
        ST_PRESENT = 2'd2,
        ST_DONE    = 2'd3
    } fetch_state_t;

    function automatic logic [7:0] opcode_of(input logic [31:0] word);
        return word[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/instr_mem.sv
// rtl/instr_mem.sv - DEPTH x 32 program store, synchronous write, asynchronous read
module instr_mem #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [31:0]       i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [31:0]       o_rd_data
);

    // Contents deliberately survive reset so a program can be re-run.
    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch FSM over instr_mem; define IFETCH_LOOP_EN to wrap pc at end of memory
module instr_fetch
    import proc_pkg::*;
#(
    parameter int         DEPTH       = 16,
    parameter int         ADDR_W      = 4,
    parameter logic [7:0] HALT_OPCODE = OP_HALT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data,
    input  logic              start,
    output logic [31:0]       instruction,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] pc,
    output logic [7:0]        fetch_count
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    fetch_state_t      r_state;
    fetch_state_t      w_next_state;
    logic [31:0]       r_instruction;
    logic [ADDR_W-1:0] r_pc;
    logic [7:0]        r_fetch_count;

    logic [31:0]       w_mem_word;
    logic              w_busy;
    logic              w_mem_we;
    logic              w_clear;
    logic              w_capture;
    logic              w_accept;
    logic              w_advance;
    logic              w_wrap;

    assign w_busy   = (r_state == ST_READ) || (r_state == ST_PRESENT);
    assign w_mem_we = load_en && !w_busy;

    instr_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .i_clk     (clk),
        .i_wr_en   (w_mem_we),
        .i_wr_addr (load_addr),
        .i_wr_data (load_data),
        .i_rd_addr (r_pc),
        .o_rd_data (w_mem_word)
    );

    always_comb begin
        w_next_state = r_state;
        w_clear      = 1'b0;
        w_capture    = 1'b0;
        w_accept     = 1'b0;
        w_advance    = 1'b0;
        w_wrap       = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_clear      = 1'b1;
                    w_next_state = ST_READ;
                end
            end
            ST_READ: begin
                // A halt word is never captured, so the last presented word stays visible.
                if (opcode_of(w_mem_word) == HALT_OPCODE) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_capture    = 1'b1;
                    w_next_state = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (instr_ready) begin
                    w_accept = 1'b1;
                    if (r_pc == LAST_ADDR) begin
`ifdef IFETCH_LOOP_EN
                        w_wrap       = 1'b1;
                        w_next_state = ST_READ;
`else
                        w_next_state = ST_DONE;
`endif
                    end else begin
                        w_advance    = 1'b1;
                        w_next_state = ST_READ;
                    end
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_instruction <= 32'd0;
            r_pc          <= '0;
            r_fetch_count <= 8'd0;
        end else begin
            r_state <= w_next_state;
            if (w_capture) begin
                r_instruction <= w_mem_word;
            end
            if (w_clear) begin
                r_pc          <= '0;
                r_fetch_count <= 8'd0;
            end else begin
                if (w_accept && (r_fetch_count != 8'hFF)) begin
                    r_fetch_count <= r_fetch_count + 8'd1;
                end
                if (w_wrap) begin
                    r_pc <= '0;
                end else if (w_advance) begin
                    r_pc <= r_pc + ADDR_W'(1);
                end
            end
        end
    end

    assign instruction = r_instruction;
    assign instr_valid = (r_state == ST_PRESENT);
    assign busy        = w_busy;
    assign done        = (r_state == ST_DONE);
    assign pc          = r_pc;
    assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - scoreboard bench for instr_fetch with randomized programs and backpressure
module tb_instr_fetch;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_en;
    logic [3:0]  load_addr;
    logic [31:0] load_data;
    logic        start;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        instr_ready;
    logic        busy;
    logic        done;
    logic [3:0]  pc;
    logic [7:0]  fetch_count;

    instr_fetch #(
        .DEPTH       (16),
        .ADDR_W      (4),
        .HALT_OPCODE (8'hFF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .start       (start),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .busy        (busy),
        .done        (done),
        .pc          (pc),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    logic [31:0] m_mem [DEPTH];
    logic [31:0] sb [$];
    int          n_pass  = 0;
    int          n_total = 0;
    int          n_hs    = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_instr = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // Monitor: every handshake pops the next expected word; a stalled word must hold.
    always @(negedge clk) begin
        if (prev_stall) begin
            check("stall_valid", {31'd0, instr_valid}, 32'd1);
            check("stall_instr", instruction, prev_instr);
        end
        if (instr_valid && instr_ready && !rst) begin
            n_hs++;
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL sb_underflow: got 0x%0h presented, want no presentation", instruction);
            end else begin
                check("sb_word", instruction, sb.pop_front());
            end
        end
        prev_stall = instr_valid && !instr_ready && !rst;
        prev_instr = instruction;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic load_word(input int a, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = 4'(a);
        load_data = d;
        m_mem[a]  = d;
        tick();
        load_en = 1'b0;
    endtask

    // Reference: words from address 0 up to (not including) the first halt, or all of memory.
    task automatic model_expect(output int cnt, output int pc_end);
        cnt    = 0;
        pc_end = DEPTH - 1;
        for (int a = 0; a < DEPTH; a++) begin
            if (m_mem[a][31:24] == 8'hFF) begin
                pc_end = a;
                break;
            end
            sb.push_back(m_mem[a]);
            cnt++;
        end
    endtask

    task automatic finish_run(input int cnt, input int pc_end, input int pct, output int cyc);
        cyc = 0;
        while (!done && cyc < 400) begin
            instr_ready = ($urandom_range(99) < pct);
            tick();
            cyc++;
        end
        instr_ready = 1'b0;
        check("end_done", {31'd0, done}, 32'd1);
        check("end_count", {24'd0, fetch_count}, cnt);
        check("end_pc", {28'd0, pc}, pc_end);
        check("end_sb_empty", sb.size(), 0);
    endtask

    task automatic run_prog(input int pct);
        int cnt, pce, cyc;
        model_expect(cnt, pce);
        start = 1'b1;
        tick();
        start = 1'b0;
        finish_run(cnt, pce, pct, cyc);
    endtask

    initial begin
        int cnt, pce, cyc, n0, h;
        logic [31:0] w;
        rst = 1'b1; load_en = 1'b0; start = 1'b0; instr_ready = 1'b0;
        load_addr = '0; load_data = '0;
        tick(); tick();
        rst = 1'b0;

        check("rst_instruction", instruction, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_pc", {28'd0, pc}, 32'd0);
        check("rst_count", {24'd0, fetch_count}, 32'd0);

        // Basic program with latency and halt timing
        load_word(0, 32'h88000302);
        load_word(1, 32'h89000503);
        load_word(2, 32'hFF000000);
        model_expect(cnt, pce);
        instr_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("lat_busy", {31'd0, busy}, 32'd1);
        check("lat_valid_read", {31'd0, instr_valid}, 32'd0);
        tick();
        check("lat_valid_present", {31'd0, instr_valid}, 32'd1);
        check("lat_first_word", instruction, 32'h88000302);
        finish_run(cnt, pce, 100, cyc);
        check("halt_latency", cyc, 4);
        check("halt_keeps_instr", instruction, 32'h89000503);

        // Restart from DONE with backpressure on the first word
        model_expect(cnt, pce);
        instr_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_done_drop", {31'd0, done}, 32'd0);
        check("restart_count", {24'd0, fetch_count}, 32'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            check("bp_valid", {31'd0, instr_valid}, 32'd1);
            check("bp_instr", instruction, 32'h88000302);
            check("bp_count", {24'd0, fetch_count}, 32'd0);
            tick();
        end
        finish_run(cnt, pce, 100, cyc);

        // Reset mid-fetch, then re-run from retained memory
        model_expect(cnt, pce);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        check("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
        check("mid_rst_pc", {28'd0, pc}, 32'd0);
        check("mid_rst_count", {24'd0, fetch_count}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        run_prog(100);

        // load_en and start ignored while busy
        model_expect(cnt, pce);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        load_en = 1'b1; load_addr = 4'd1; load_data = 32'h12345678;
        start = 1'b1;
        tick();
        load_en = 1'b0;
        start = 1'b0;
        check("ign_pc", {28'd0, pc}, 32'd0);
        check("ign_count", {24'd0, fetch_count}, 32'd0);
        check("ign_valid", {31'd0, instr_valid}, 32'd1);
        check("ign_instr", instruction, 32'h88000302);
        finish_run(cnt, pce, 100, cyc);

        // Simultaneous load and start from DONE: first READ sees the new word
        m_mem[0] = 32'h8A000011;
        model_expect(cnt, pce);
        load_en = 1'b1; load_addr = 4'd0; load_data = 32'h8A000011;
        start = 1'b1;
        tick();
        load_en = 1'b0;
        start = 1'b0;
        finish_run(cnt, pce, 100, cyc);

        // End of memory without halt
        for (int a = 0; a < DEPTH; a++) load_word(a, 32'h8A000007);
`ifdef IFETCH_LOOP_EN
        for (int i = 0; i < 20; i++) sb.push_back(32'h8A000007);
        n0 = n_hs;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while ((n_hs - n0) < 20 && cyc < 200) begin
            instr_ready = 1'b1;
            tick();
            cyc++;
        end
        instr_ready = 1'b0;
        check("loop_busy", {31'd0, busy}, 32'd1);
        check("loop_count", {24'd0, fetch_count}, 32'd20);
        check("loop_pc", {28'd0, pc}, 20 % DEPTH);
        check("loop_sb_empty", sb.size(), 0);
        do_reset();
`else
        n0 = n_hs;
        run_prog(100);
        check("eom_presentations", n_hs - n0, 16);
`endif

        // Randomized programs and ready patterns
        for (int t = 0; t < 20; t++) begin
`ifdef IFETCH_LOOP_EN
            h = $urandom_range(0, DEPTH - 1);
`else
            h = $urandom_range(0, DEPTH);
`endif
            for (int a = 0; a < DEPTH; a++) begin
                w = $urandom;
                if (a == h) w[31:24] = 8'hFF;
                load_word(a, w);
            end
            run_prog($urandom_range(30, 100));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
